// File: rtl/zoran_nios_send_fifo_port_if.sv
// Bus bundle for the Nios send FIFO port: the Avalon-MM slave register port
// plus the outbound valid/ready stream and the level interrupt.
// The master side is the Nios data master together with the downstream
// processing element. The slave side is the FIFO port itself.

interface zoran_nios_send_fifo_port_if #(
   parameter int DATA_WIDTH = 32
);

   // Avalon-MM register access
   logic [1:0]            address;
   logic                  chipselect;
   logic                  write_n;
   logic [31:0]           writedata;
   logic [31:0]           readdata;

   // Outbound stream
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   // Level interrupt
   logic                  irq;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      output out_ready,
      input  readdata,
      input  out_data,
      input  out_valid,
      input  irq
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      input  out_ready,
      output readdata,
      output out_data,
      output out_valid,
      output irq
   );

endinterface

// File: rtl/zoran_nios_send_fifo_port.sv
// Nios send-data port with a DEPTH-entry FIFO.
//
// The Nios core writes outbound words through register 0. They queue in a
// small circular buffer and drain to the downstream element over a
// valid/ready stream. Registers:
//    0 DATA    - write pushes a word and updates the shadow; read returns the shadow
//    1 STATUS  - {level[16:8], overflow[2], full[1], empty[0]}; write bit2 clears overflow
//    2 CONTROL - {irq_en[1], enable[0]}
//    3 SENT    - count of completed stream transfers; any write clears it
// All state is synchronous to clk and cleared by a synchronous active-high reset.

module zoran_nios_send_fifo_port #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   zoran_nios_send_fifo_port_if.slave bus
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LEVEL_W = PTR_W + 1;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;
   localparam logic [1:0] ADDR_SENT    = 2'd3;

   // FIFO storage and bookkeeping
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [LEVEL_W-1:0]    level;

   // Register file
   logic [DATA_WIDTH-1:0] shadow;
   logic                  overflow;
   logic                  enable;
   logic                  irq_en;
   logic [31:0]           sent;

   // Decoded strobes
   logic bus_write;
   logic wr_data;
   logic wr_status;
   logic wr_control;
   logic wr_sent;
   logic empty;
   logic full;
   logic out_valid_int;
   logic pop;
   logic push_accept;
   logic overflow_set;
   logic [31:0] read_mux;

   assign bus_write  = bus.chipselect && !bus.write_n;
   assign wr_data    = bus_write && (bus.address == ADDR_DATA);
   assign wr_status  = bus_write && (bus.address == ADDR_STATUS);
   assign wr_control = bus_write && (bus.address == ADDR_CONTROL);
   assign wr_sent    = bus_write && (bus.address == ADDR_SENT);

   assign empty = (level == '0);
   assign full  = (level == LEVEL_W'(DEPTH));

   // The head word is only offered while enabled; there is no same-cycle
   // bypass, so a word written into an empty FIFO is visible one edge later.
   assign out_valid_int = enable && !empty;
   assign pop           = out_valid_int && bus.out_ready;

   // A push into a full FIFO still succeeds when a pop frees a slot in the
   // same cycle; only a push that finds no room is dropped and flagged.
   assign push_accept  = wr_data && (!full || pop);
   assign overflow_set = wr_data && full && !pop;

   assign bus.out_valid = out_valid_int;
   assign bus.out_data  = out_valid_int ? mem[rd_ptr] : '0;
   assign bus.irq       = irq_en && empty;
   assign bus.readdata  = read_mux;

   // Storage array writes; contents need no reset because level gates visibility.
   always_ff @(posedge clk) begin
      if (push_accept) begin
         mem[wr_ptr] <= bus.writedata[DATA_WIDTH-1:0];
      end
   end

   // Pointers and occupancy; a reset discards every queued word at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_accept, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Shadow of the last DATA write, kept even when the word itself is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         shadow <= '0;
      end else if (wr_data) begin
         shadow <= bus.writedata[DATA_WIDTH-1:0];
      end
   end

   // Sticky overflow flag; a fresh overflow wins over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (overflow_set) begin
         overflow <= 1'b1;
      end else if (wr_status && bus.writedata[2]) begin
         overflow <= 1'b0;
      end
   end

   // Control bits; the port comes out of reset enabled with the interrupt masked.
   always_ff @(posedge clk) begin
      if (reset) begin
         enable <= 1'b1;
         irq_en <= 1'b0;
      end else if (wr_control) begin
         enable <= bus.writedata[0];
         irq_en <= bus.writedata[1];
      end
   end

   // Transfer counter; a clearing write takes priority over a pop in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         sent <= '0;
      end else if (wr_sent) begin
         sent <= '0;
      end else if (pop) begin
         sent <= sent + 32'd1;
      end
   end

   // Zero-wait-state read mux with no side effects; unused bits read as zero.
   always_comb begin
      read_mux = '0;
      case (bus.address)
         ADDR_DATA: begin
            read_mux[DATA_WIDTH-1:0] = shadow;
         end
         ADDR_STATUS: begin
            read_mux[0]             = empty;
            read_mux[1]             = full;
            read_mux[2]             = overflow;
            read_mux[8 +: LEVEL_W]  = level;
         end
         ADDR_CONTROL: begin
            read_mux[0] = enable;
            read_mux[1] = irq_en;
         end
         ADDR_SENT: begin
            read_mux = sent;
         end
         default: begin
            read_mux = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_zoran_nios_send_fifo_port.sv
// Self-checking bench for zoran_nios_send_fifo_port.
// Stream words are pushed onto a scoreboard queue when the bus write is
// accepted and popped and compared when a handshake is seen on the stream.
// Inputs change 1 time unit after the rising edge; the stream monitor samples
// on the falling edge.

module tb_zoran_nios_send_fifo_port;

   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   zoran_nios_send_fifo_port_if #(.DATA_WIDTH(DW)) bus ();

   zoran_nios_send_fifo_port #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb [$];
   bit          model_en;
   bit          model_irq_en;
   bit          model_ovf;
   bit          mon_on = 1'b0;
   logic [31:0] model_sent;
   logic [31:0] model_shadow;
   logic [31:0] rd;

   // Advance one clock, leaving the bench just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Combinational register read; no clock edge is consumed.
   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      #1;
      d              = bus.readdata;
      bus.chipselect = 1'b0;
      bus.address    = 2'd0;
   endtask

   // Single-cycle register write, updating the reference model afterwards.
   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      bit will_pop;
      bit accept;
      will_pop = bus.out_ready && model_en && (sb.size() != 0);
      accept   = (sb.size() < DEPTH) || will_pop;
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      tick();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      case (a)
         2'd0: begin
            model_shadow = d;
            if (accept) sb.push_back(d);
            else        model_ovf = 1'b1;
         end
         2'd1: if (d[2]) model_ovf = 1'b0;
         2'd2: begin
            model_en     = d[0];
            model_irq_en = d[1];
         end
         default: model_sent = 32'd0;
      endcase
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] e;
      e       = '0;
      e[0]    = (sb.size() == 0);
      e[1]    = (sb.size() == DEPTH);
      e[2]    = model_ovf;
      e[16:8] = 9'(sb.size());
      return e;
   endfunction

   // Hold out_ready until the scoreboard empties, bounded by a cycle budget.
   task automatic drain();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
      bus.out_ready = 1'b0;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout: %0d words still queued, required 0", sb.size());
      end
   endtask

   // Stream monitor: out_valid against the model and scoreboard on each handshake.
   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         if (bus.out_valid !== (model_en && sb.size() != 0)) begin
            errors++;
            $display("[TB] FAIL out_valid: got %b required %b", bus.out_valid,
                     (model_en && sb.size() != 0));
         end
         if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            model_sent = model_sent + 32'd1;
            if (sb.size() == 0) begin
               errors++;
               $display("[TB] FAIL stream_word: got %h with nothing queued", bus.out_data);
            end else begin
               logic [31:0] exp;
               exp = sb.pop_front();
               if (bus.out_data !== exp) begin
                  errors++;
                  $display("[TB] FAIL stream_word: got %h required %h", bus.out_data, exp);
               end
            end
         end
      end
   end

   task automatic test_reset();
      reset          = 1'b1;
      bus.address    = 2'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      bus.out_ready  = 1'b0;
      tick();
      tick();
      reset        = 1'b0;
      sb.delete();
      model_en     = 1'b1;
      model_irq_en = 1'b0;
      model_ovf    = 1'b0;
      model_sent   = 32'd0;
      model_shadow = 32'd0;
      mon_on       = 1'b1;
      read_reg(2'd1, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin
         errors++; $display("[TB] FAIL reset_status: got %h required 00000001", rd);
      end
      read_reg(2'd2, rd);
      checks++;
      if (rd !== 32'h0000_0001) begin
         errors++; $display("[TB] FAIL reset_control: got %h required 00000001", rd);
      end
      read_reg(2'd3, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_sent: got %h required 00000000", rd);
      end
      read_reg(2'd0, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_data: got %h required 00000000", rd);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got valid=%b data=%h irq=%b required 0/0/0",
                  bus.out_valid, bus.out_data, bus.irq);
      end
   endtask

   task automatic test_basic();
      do_write(2'd0, 32'hA5A5_A5A5);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5_A5A5) begin
         errors++;
         $display("[TB] FAIL first_word: got valid=%b data=%h required 1/a5a5a5a5",
                  bus.out_valid, bus.out_data);
      end
      do_write(2'd0, 32'h1234_5678);
      read_reg(2'd1, rd);
      checks++;
      if (rd !== exp_status()) begin
         errors++; $display("[TB] FAIL basic_status: got %h required %h", rd, exp_status());
      end
      read_reg(2'd0, rd);
      checks++;
      if (rd !== model_shadow) begin
         errors++; $display("[TB] FAIL basic_shadow: got %h required %h", rd, model_shadow);
      end
      bus.out_ready = 1'b1;
      tick();
      tick();
      bus.out_ready = 1'b0;
      read_reg(2'd1, rd);
      checks++;
      if (rd !== exp_status()) begin
         errors++; $display("[TB] FAIL basic_drained: got %h required %h", rd, exp_status());
      end
      read_reg(2'd3, rd);
      checks++;
      if (rd !== model_sent) begin
         errors++; $display("[TB] FAIL basic_sent: got %h required %h", rd, model_sent);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 9; i++) begin
         do_write(2'd0, 32'(i));
         if (i >= 8) begin
            read_reg(2'd1, rd);
            checks++;
            if (rd !== exp_status()) begin
               errors++;
               $display("[TB] FAIL overflow_status_w%0d: got %h required %h", i, rd, exp_status());
            end
         end
      end
      read_reg(2'd0, rd);
      checks++;
      if (rd !== 32'd9) begin
         errors++; $display("[TB] FAIL dropped_shadow: got %h required 00000009", rd);
      end
      drain();
      do_write(2'd1, 32'h4);
      read_reg(2'd1, rd);
      checks++;
      if (rd !== exp_status()) begin
         errors++; $display("[TB] FAIL overflow_clear: got %h required %h", rd, exp_status());
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < DEPTH; i++) do_write(2'd0, 32'h10 + 32'(i));
      bus.out_ready = 1'b1;
      do_write(2'd0, 32'h77);
      read_reg(2'd1, rd);
      checks++;
      if (rd !== exp_status()) begin
         errors++; $display("[TB] FAIL full_push_pop: got %h required %h", rd, exp_status());
      end
      // Clear SENT while a pop is also happening; the clear must win.
      do_write(2'd3, 32'h0);
      bus.out_ready = 1'b0;
      read_reg(2'd3, rd);
      checks++;
      if (rd !== model_sent) begin
         errors++; $display("[TB] FAIL sent_clear_vs_pop: got %h required %h", rd, model_sent);
      end
      drain();
   endtask

   task automatic test_irq();
      do_write(2'd2, 32'h2);
      checks++;
      if (bus.irq !== (model_irq_en && sb.size() == 0)) begin
         errors++; $display("[TB] FAIL irq_empty: got %b required 1", bus.irq);
      end
      do_write(2'd0, 32'h55);
      checks++;
      if (bus.irq !== (model_irq_en && sb.size() == 0) || bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL irq_queued: got irq=%b valid=%b required 0/0", bus.irq, bus.out_valid);
      end
      bus.out_ready = 1'b1;
      tick();
      tick();
      do_write(2'd2, 32'h3);
      drain();
      checks++;
      if (bus.irq !== (model_irq_en && sb.size() == 0)) begin
         errors++; $display("[TB] FAIL irq_return: got %b required 1", bus.irq);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) do_write(2'd0, 32'hC0 + 32'(i));
      read_reg(2'd1, rd);
      checks++;
      if (rd !== exp_status()) begin
         errors++; $display("[TB] FAIL pre_reset_level: got %h required %h", rd, exp_status());
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb.delete();
      model_en     = 1'b1;
      model_irq_en = 1'b0;
      model_ovf    = 1'b0;
      model_sent   = 32'd0;
      model_shadow = 32'd0;
      read_reg(2'd1, rd);
      checks++;
      if (rd !== exp_status()) begin
         errors++; $display("[TB] FAIL post_reset_status: got %h required %h", rd, exp_status());
      end
      read_reg(2'd3, rd);
      checks++;
      if (rd !== model_sent) begin
         errors++; $display("[TB] FAIL post_reset_sent: got %h required %h", rd, model_sent);
      end
      read_reg(2'd2, rd);
      checks++;
      if (rd !== 32'h1) begin
         errors++; $display("[TB] FAIL post_reset_control: got %h required 00000001", rd);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.irq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post_reset_outputs: got valid=%b irq=%b required 0/0",
                  bus.out_valid, bus.irq);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_push_pop();
      test_irq();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

endmodule

// File: doc/zoran_nios_send_fifo_port.md
# zoran_nios_send_fifo_port

Parametrised successor to the Nios single-register send-data output port. The Nios core writes outbound words over an Avalon-MM slave into a DEPTH-entry FIFO. The block drains them to a downstream processing element over a valid/ready stream, and exposes status, control, an overflow flag, a transfer counter and an empty interrupt. It sits between the Nios data master and the inter-processor datapath of the HMPSoC.

## Interface
- DATA_WIDTH, 32: stream word width, 1..32; writedata[DATA_WIDTH-1:0] is used.
- DEPTH, 8: FIFO entries, power of two, 2..256.
- clk  in  1  single clock domain; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect && !write_n.
- writedata  in  32  write data.
- readdata  out  32  combinational read mux, zero wait states; reads have no side effects.
- out_data  out  DATA_WIDTH  FIFO head word; forced to 0 when out_valid=0.
- out_valid  out  1  head word available.
- out_ready  in  1  downstream accepts the word.
- irq  out  1  level interrupt, irq = irq_en && empty.

## Operation
- Register map (32-bit, unused bits read 0):
  - 0 DATA:
    - Write pushes writedata[DATA_WIDTH-1:0] into the FIFO and also updates a shadow register.
    - Read returns the shadow value, zero-extended.
  - 1 STATUS:
    - Read fields: bit0 empty, bit1 full, bit2 overflow (sticky), bits[16:8] level (0..DEPTH).
    - Write with writedata[2]=1 clears overflow; other bits are ignored.
  - 2 CONTROL (R/W): bit0 enable, bit1 irq_en.
  - 3 SENT:
    - Read returns a 32-bit count of completed stream transfers, wrapping 0xFFFFFFFF→0.
    - Any write clears it to 0.
- Push and pop rules:
  - push = DATA write; pop = out_valid && out_ready.
  - out_valid = enable && !empty.
  - Push when full and no pop in the same cycle: the word is dropped, overflow is set, and the shadow is still updated.
  - Push and pop in the same cycle: both take effect and level is unchanged. This includes the full case, where no overflow is raised.
  - Push into an empty FIFO: out_valid rises the next cycle. There is no same-cycle bypass.
  - Pop from an empty FIFO cannot occur.
- Pointers and level:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - level is log2(DEPTH)+1 bits. full = (level==DEPTH); empty = (level==0).
- Enable:
  - Clearing enable drops out_valid the following cycle; FIFO contents are retained.
  - Writes are still accepted while enable=0.
  - Downstream must tolerate out_valid withdrawal only on a disable.
- SENT:
  - Increments once per pop.
  - A SENT write and a pop in the same cycle leaves SENT = 0.
- Overflow: a clear-write and a new overflow in the same cycle leaves overflow = 1.

## Timing
- Reset values:
  - FIFO empty, level 0, overflow 0, shadow 0, SENT 0.
  - enable 1, irq_en 0.
  - out_valid 0, out_data 0, irq 0, readdata follows address.
- A reset asserted mid-stream empties the FIFO in one cycle. Queued words are discarded.
- Write at edge N: level, full and empty are updated after edge N, and out_valid is high during cycle N+1.
- Pop at edge N: the next head word is on out_data during cycle N+1. A sustained out_ready drains one word per cycle.
- readdata reflects register state after the most recent edge. It is combinational from address.
- irq follows empty and irq_en with the same one-edge latency as the registers.

## Test plan
- Reset, then hold out_ready=0:
  - STATUS reads 0x00000001 and CONTROL reads 0x1.
  - out_valid=0, out_data=0, irq=0.
- Write DATA 0xA5A5A5A5, then 0x12345678, with out_ready=0:
  - out_valid=1 from the cycle after the first write, with out_data=0xA5A5A5A5.
  - STATUS level=2, DATA reads 0x12345678.
  - Raise out_ready for 2 cycles: words are accepted in order, then empty; SENT reads 2.
- DEPTH=8, out_ready=0, write 9 words 1..9:
  - full=1 after the 8th write; the 9th is dropped and overflow=1.
  - Drain yields 1..8.
  - Write STATUS 0x4: overflow reads 0.
- FIFO full, out_ready=1, write 0x77 in the same cycle:
  - level stays 8 and overflow stays 0.
  - 0x77 emerges last, after wrap-around.
- Set CONTROL=0x2 with the FIFO empty: irq=1.
  - Write one word with CONTROL bit0=0: irq=0 next cycle and out_valid stays 0.
  - Set enable: word is delivered, then irq returns to 1.
- Mid-stream reset with level=5: next cycle level=0, out_valid=0, SENT=0, CONTROL=0x1.
